// File: rtl/fetch_npc_stage.sv
// MIPS F-stage: fetch PC, next-PC resolution from the instruction in D, F/D register, counters.
// Optional fetch alignment/range fault check is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_npc_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             PC_en,
  input  logic             IR_D_en,
  input  logic [31:0]      im_rdata,
  input  logic [31:0]      rs_fwd_D,
  input  logic             cmp_eq_D,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      PC_F,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC8_D,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt,
  output logic             fetch_err
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc8_d_q, pc8_d_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]  op, funct;
  logic        is_beq, is_j, is_jal, is_jr;
  logic [31:0] br_off;
  logic [31:0] npc;

  assign op     = ir_d_q[31:26];
  assign funct  = ir_d_q[5:0];
  assign is_beq = (op == 6'b000100);
  assign is_j   = (op == 6'b000010);
  assign is_jal = (op == 6'b000011);
  assign is_jr  = (op == 6'b000000) && (funct == 6'b001000);
  assign br_off = {{14{ir_d_q[15]}}, ir_d_q[15:0], 2'b00};

  // The delay slot is already at PC_F, so the fall-through path is PC_F+4, not PC_D+8.
  always_comb begin
    npc = pc_f_q + 32'd4;
    if (is_beq && cmp_eq_D) begin
      npc = pc_d_q + 32'd4 + br_off;
    end else if (is_j || is_jal) begin
      npc = {pc_d_q[31:28], ir_d_q[25:0], 2'b00};
    end else if (is_jr) begin
      npc = rs_fwd_D;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] fetch_off;
  logic        fetch_fault;

  assign fetch_off   = pc_f_q - PC_RESET;
  assign fetch_fault = (pc_f_q[1:0] != 2'b00) || ((fetch_off >> (IM_AW + 2)) != 32'h0);
  assign fetch_err   = fetch_err_q;
`else
  assign fetch_err   = 1'b0;
`endif

  always_comb begin
    pc_f_d      = pc_f_q;
    ir_d_d      = ir_d_q;
    pc_d_d      = pc_d_q;
    pc8_d_d     = pc8_d_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_err_d = fetch_err_q;
`endif
    if (PC_en) begin
      pc_f_d = npc;
    end else begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (IR_D_en) begin
      ir_d_d      = im_rdata;
      pc_d_d      = pc_f_q;
      pc8_d_d     = pc_f_q + 32'd8;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
      // A faulty fetch enters D as a nop but keeps its PC for debug.
      if (fetch_fault) begin
        ir_d_d      = 32'h0;
        fetch_err_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f_q      <= PC_RESET;
      ir_d_q      <= 32'h0;
      pc_d_q      <= PC_RESET;
      pc8_d_q     <= PC_RESET + 32'd8;
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      pc_f_q      <= pc_f_d;
      ir_d_q      <= ir_d_d;
      pc_d_q      <= pc_d_d;
      pc8_d_q     <= pc8_d_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  assign im_addr   = pc_f_q[IM_AW+1:2];
  assign PC_F      = pc_f_q;
  assign IR_D      = ir_d_q;
  assign PC_D      = pc_d_q;
  assign PC8_D     = pc8_d_q;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_npc_stage.sv
// Directed bench for fetch_npc_stage: reset, sequential fetch, beq/j/jal/jr redirects, stalls,
// asynchronous reset during a stall, and the FETCH_ALIGN_CHECK_EN fault path.
module tb_fetch_npc_stage;

  localparam int unsigned IM_AW = 10;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] ExpIrFault = 32'h0000_0000;
  localparam logic [31:0] ExpErr     = 32'd1;
`else
  localparam logic [31:0] ExpIrFault = 32'h2405_0005;
  localparam logic [31:0] ExpErr     = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             PC_en;
  logic             IR_D_en;
  logic [31:0]      im_rdata;
  logic [31:0]      rs_fwd_D;
  logic             cmp_eq_D;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      PC_F;
  logic [31:0]      IR_D;
  logic [31:0]      PC_D;
  logic [31:0]      PC8_D;
  logic [31:0]      fetch_cnt;
  logic [31:0]      stall_cnt;
  logic             fetch_err;

  logic [31:0] imem [0:1023];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign im_rdata = imem[im_addr];

  fetch_npc_stage #(
    .PC_RESET(32'h0000_3000),
    .IM_AW   (IM_AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .PC_en    (PC_en),
    .IR_D_en  (IR_D_en),
    .im_rdata (im_rdata),
    .rs_fwd_D (rs_fwd_D),
    .cmp_eq_D (cmp_eq_D),
    .im_addr  (im_addr),
    .PC_F     (PC_F),
    .IR_D     (IR_D),
    .PC_D     (PC_D),
    .PC8_D    (PC8_D),
    .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt),
    .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " PC_F"}, PC_F, 32'h3000);
    check({tag, " IR_D"}, IR_D, 32'h0);
    check({tag, " PC_D"}, PC_D, 32'h3000);
    check({tag, " PC8_D"}, PC8_D, 32'h3008);
    check({tag, " fetch_cnt"}, fetch_cnt, 32'h0);
    check({tag, " stall_cnt"}, stall_cnt, 32'h0);
    check({tag, " fetch_err"}, {31'h0, fetch_err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    imem[0] = 32'h3401_0005;  // 0x3000 ori
    imem[4] = 32'h1000_0003;  // 0x3010 beq +3
    imem[5] = 32'h2402_0001;  // 0x3014 delay slot
    imem[8] = 32'h2403_0002;  // 0x3020 branch target
    reset_n  = 1'b1;
    PC_en    = 1'b1;
    IR_D_en  = 1'b1;
    cmp_eq_D = 1'b0;
    rs_fwd_D = 32'h0;

    // Reset and first fetch
    #1 reset_n = 1'b0;
    #1;
    check_reset_vals("rst");
    check("rst im_addr", {22'h0, im_addr}, 32'h0);
    step(2);
    reset_n = 1'b1;
    check("c0 PC_F", PC_F, 32'h3000);
    step(1);
    check("c1 IR_D", IR_D, 32'h3401_0005);
    check("c1 PC_D", PC_D, 32'h3000);
    check("c1 PC_F", PC_F, 32'h3004);
    check("c1 fetch_cnt", fetch_cnt, 32'd1);
    step(3);
    check("seq PC_F", PC_F, 32'h3010);
    check("seq im_addr", {22'h0, im_addr}, 32'h4);
    step(1);
    check("beq IR_D", IR_D, 32'h1000_0003);
    check("beq PC_D", PC_D, 32'h3010);
    check("beq PC8_D", PC8_D, 32'h3018);
    check("beq PC_F", PC_F, 32'h3014);

    // Taken beq held in D across a 3-cycle stall
    cmp_eq_D = 1'b1;
    PC_en    = 1'b0;
    IR_D_en  = 1'b0;
    step(3);
    check("stall PC_F", PC_F, 32'h3014);
    check("stall IR_D", IR_D, 32'h1000_0003);
    check("stall PC_D", PC_D, 32'h3010);
    check("stall stall_cnt", stall_cnt, 32'd3);
    check("stall fetch_cnt", fetch_cnt, 32'd5);
    PC_en   = 1'b1;
    IR_D_en = 1'b1;
    step(1);
    check("taken PC_F", PC_F, 32'h3020);
    check("taken slot IR_D", IR_D, 32'h2402_0001);
    check("taken slot PC_D", PC_D, 32'h3014);
    check("taken fetch_cnt", fetch_cnt, 32'd6);
    check("taken stall_cnt", stall_cnt, 32'd3);
    cmp_eq_D = 1'b0;
    step(1);
    check("target PC_F", PC_F, 32'h3024);
    check("target IR_D", IR_D, 32'h2403_0002);
    check("target PC_D", PC_D, 32'h3020);

    // Not-taken beq, then asynchronous reset during a stall
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(5);
    check("nt beq IR_D", IR_D, 32'h1000_0003);
    step(1);
    check("nt PC_F", PC_F, 32'h3018);
    check("nt IR_D", IR_D, 32'h2402_0001);
    check("nt PC_D", PC_D, 32'h3014);
    PC_en   = 1'b0;
    IR_D_en = 1'b0;
    step(1);
    check("stall2 stall_cnt", stall_cnt, 32'd1);
    check("stall2 PC_F", PC_F, 32'h3018);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("async");

    // jal / jr redirects with delay slots
    imem[0]  = 32'h0C00_0C00;  // 0x3000 jal 0x3000
    imem[1]  = 32'h03E0_0008;  // 0x3004 jr $ra
    imem[16] = 32'h2405_0005;  // 0x3040
    rs_fwd_D = 32'h3040;
    PC_en    = 1'b1;
    IR_D_en  = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    check("jal IR_D", IR_D, 32'h0C00_0C00);
    check("jal PC8_D", PC8_D, 32'h3008);
    check("jal PC_F", PC_F, 32'h3004);
    step(1);
    check("jal tgt PC_F", PC_F, 32'h3000);
    check("jal slot IR_D", IR_D, 32'h03E0_0008);
    check("jal slot PC_D", PC_D, 32'h3004);
    step(1);
    check("jr PC_F", PC_F, 32'h3040);
    check("jr slot IR_D", IR_D, 32'h0C00_0C00);
    check("jr slot PC_D", PC_D, 32'h3000);
    step(1);
    check("jr tgt IR_D", IR_D, 32'h2405_0005);
    check("jr tgt PC_D", PC_D, 32'h3040);
    check("jr tgt PC8_D", PC8_D, 32'h3048);
    check("jr tgt PC_F", PC_F, 32'h3000);
    check("jr fetch_cnt", fetch_cnt, 32'd4);

    // jr to a misaligned address
    rs_fwd_D = 32'h3042;
    step(2);
    check("mis jr IR_D", IR_D, 32'h03E0_0008);
    step(1);
    check("mis PC_F", PC_F, 32'h3042);
    check("mis pre fetch_err", {31'h0, fetch_err}, 32'h0);
    step(1);
    check("mis IR_D", IR_D, ExpIrFault);
    check("mis PC_D", PC_D, 32'h3042);
    check("mis PC8_D", PC8_D, 32'h304A);
    check("mis fetch_err", {31'h0, fetch_err}, ExpErr);
    check("mis PC_F after", PC_F, 32'h3000);
    step(1);
    check("sticky IR_D", IR_D, 32'h0C00_0C00);
    check("sticky fetch_err", {31'h0, fetch_err}, ExpErr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_npc_stage.md
Name: fetch_npc_stage

Overview:
- F-stage of the 5-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and owns the F/D pipeline register (IR_D, PC_D, PC8_D).
- Resolves next-PC from the instruction in D: beq, j, jal, jr, with one branch-delay-slot semantics.
- Obeys PC_en / IR_D_en from the hazard unit.
- Keeps fetch and stall performance counters.

Parameters:
- PC_RESET, 32'h00003000, PC value after reset.
- IM_AW, 10, instruction-memory word-address width; range check uses it.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- PC_en  in  1  from hazard unit; 1 = PC may update
- IR_D_en  in  1  from hazard unit; 1 = F/D register may load
- im_rdata  in  32  instruction at im_addr, combinational read
- rs_fwd_D  in  32  forwarded GPR[rs] of IR_D (jr target)
- cmp_eq_D  in  1  forwarded GPR[rs]==GPR[rt] for IR_D
- im_addr  out  IM_AW  word address = PC_F[IM_AW+1:2]
- PC_F  out  32  current fetch PC
- IR_D  out  32  instruction in D
- PC_D  out  32  PC of IR_D
- PC8_D  out  32  PC_D+8, the jal link value
- fetch_cnt  out  32  instructions loaded into D
- stall_cnt  out  32  cycles with PC_en=0
- fetch_err  out  1  sticky fault flag; 0 unless FETCH_ALIGN_CHECK_EN

Behaviour:
- Reset (async, reset_n=0) sets: PC_F=PC_RESET, IR_D=0 (nop), PC_D=PC_RESET, PC8_D=PC_RESET+8, fetch_cnt=0, stall_cnt=0, fetch_err=0.
- Release of reset is synchronous to clk. Reset asserted mid-stall or mid-redirect overrides everything.
- Decode of IR_D (op=[31:26], funct=[5:0]):
  - beq: op 000100
  - j: op 000010
  - jal: op 000011
  - jr: op 0, funct 001000
- NPC priority:
  - beq & cmp_eq_D: PC_D+4+(sext(IR_D[15:0])<<2)
  - j or jal: {PC_D[31:28], IR_D[25:0], 2'b00}
  - jr: rs_fwd_D
  - otherwise: PC_F+4
  - Not-taken beq selects PC_F+4.
- Arithmetic is 32-bit and wraps modulo 2^32; no overflow detection.
- Delay slot: when IR_D is a control-transfer instruction, the instruction at PC_F (PC_D+4) is already in flight and is always executed. No flush path exists.
- Posedge with PC_en=1: PC_F<=NPC.
- Posedge with PC_en=0: PC_F holds. The redirect is ignored that cycle and re-evaluated next cycle, because IR_D also holds.
- Posedge with IR_D_en=1: IR_D<=im_rdata, PC_D<=PC_F, PC8_D<=PC_F+8, fetch_cnt+=1.
- Posedge with IR_D_en=0: F/D register holds.
- PC_en=0 while IR_D_en=1 is not produced by the hazard unit. If it occurs, each register obeys its own enable independently.
- stall_cnt increments on every posedge with PC_en=0.
- Both counters wrap from 32'hFFFFFFFF to 0.
- Latency: instruction at PC_F appears on IR_D one cycle later when unstalled. A taken branch in D redirects PC_F at the same edge that the delay slot enters D.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined, a fetch is faulty if PC_F[1:0]!=0 or (PC_F-PC_RESET)>>2 >= 2^IM_AW. On an IR_D load from a faulty fetch:
  - IR_D<=32'h0 instead of im_rdata.
  - fetch_err<=1, sticky until reset.
  - PC_D loads normally.
- When undefined, no check logic exists, fetch_err is tied 0, and IR_D always loads im_rdata.

Test Plan:
- Reset then release, im_rdata=32'h3401_0005, both enables 1 -> cycle0 PC_F=0x3000; cycle1 IR_D=0x34010005, PC_D=0x3000, PC_F=0x3004, fetch_cnt=1.
- beq with imm=0x0003 in D at PC_D=0x3010, cmp_eq_D=1 -> next PC_F=0x3020; delay slot PC_D=0x3014 is loaded. With cmp_eq_D=0 -> PC_F=0x3018.
- jal 0x0C000C00 at PC_D=0x3000 -> PC_F=0x00003000, PC8_D=0x3008 while jal in D. jr with rs_fwd_D=0x3040 -> PC_F=0x3040 after the delay slot.
- Hold PC_en=IR_D_en=0 for 3 cycles while beq taken is in D -> PC_F, IR_D, PC_D unchanged, stall_cnt=3. After release the redirect takes effect once.
- Assert reset_n=0 between clock edges during a stall -> outputs return to reset values immediately, without waiting for clk.
- With FETCH_ALIGN_CHECK_EN, jr to 0x3042 -> next IR_D=0, fetch_err=1 and stays 1. Without the macro -> IR_D=im_rdata, fetch_err=0.
